// File: rtl/ctrl_frame_pkg.sv
// Shared definitions for the control-frame fetch and inject paths: address map,
// header flag position, config register layout and FSM encodings.
package ctrl_frame_pkg;

    localparam logic [7:0] FetchBufBase = 8'h04;
    localparam logic [7:0] TxBufBase    = 8'h05;
    localparam logic [7:0] FetchCfgBase = 8'h14;
    localparam logic [7:0] TxCfgBase    = 8'h15;

    // Header bit that would make the switch return the frame to the CPU port
    localparam int unsigned HdrCtrlBit = 114;

    localparam int unsigned CfgBusyBit = 31;
    localparam int unsigned CfgSendBit = 30;
    localparam int unsigned CfgErrBit  = 29;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBody   = 2'd1,
        StHeader = 2'd2
    } frame_state_e;

    function automatic logic [5:0] clamp_len(input logic [5:0] len, input logic [5:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/ctrl_tx_buf.sv
// 16x32 frame buffer: byte-strobed write port, word readback port, byte fetch port
// and a tap of words 0..3 so the header can be captured in a single cycle.
module ctrl_tx_buf (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [3:0]   wr_strb,
    input  logic [31:0]  wr_data,
    input  logic [3:0]   rd_idx,
    output logic [31:0]  rd_data,
    input  logic [5:0]   fetch_idx,
    output logic [7:0]   fetch_byte,
    output logic [127:0] hdr_words
);

    logic [31:0] mem [16];
    logic [31:0] fetch_word;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data    = mem[rd_idx];
    assign fetch_word = mem[fetch_idx[5:2]];
    assign fetch_byte = fetch_word[{fetch_idx[1:0], 3'b000} +: 8];
    assign hdr_words  = {mem[3], mem[2], mem[1], mem[0]};

endmodule

// File: rtl/ctrl_frame_injector.sv
// CPU-to-switch control frame injector: buffers one frame written over iomem and
// pushes the body bytes, then the header word, into the switch FIFOs.
module ctrl_frame_injector
    import ctrl_frame_pkg::*;
#(
    parameter int unsigned HEADER_DWIDTH = 128,
    parameter int unsigned MAX_BODY      = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [HEADER_DWIDTH-1:0] h_fifo_din,
    output logic                     h_fifo_wren,
    input  logic                     h_fifo_full,
    output logic [8:0]               b_fifo_din,
    output logic                     b_fifo_wren,
    input  logic                     b_fifo_full,
    input  logic                     iomem_valid,
    output logic                     iomem_ready,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic [31:0]              iomem_rdata
);

    localparam logic [5:0] MaxLen = 6'(MAX_BODY);

    frame_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d, flen_q, flen_d, len_q, len_d;
    logic [7:0] sent_q, sent_d;
    logic       err_q, err_d, ready_q;
    logic [31:0] rdata_q, rdata_d, rd_word, cfg_word;
    logic [8:0] b_din_q;
    logic [HEADER_DWIDTH-1:0] hdr_q, hdr_flat;
    logic [127:0] hdr_words;
    logic [7:0] fetch_byte;
    logic       buf_sel, cfg_sel, req_acc, send_req, len_wr, err_clr, err_set, busy;
    logic       unused_bits;

    assign buf_sel  = iomem_addr[31:24] == TxBufBase;
    assign cfg_sel  = iomem_addr[31:24] == TxCfgBase;
    // ready_q gating keeps a held valid from being acknowledged twice
    assign req_acc  = iomem_valid && !ready_q && (buf_sel || cfg_sel);
    assign send_req = req_acc && cfg_sel && iomem_wstrb[3] && iomem_wdata[CfgSendBit];
    assign err_clr  = req_acc && cfg_sel && iomem_wstrb[3] && iomem_wdata[CfgErrBit];
    assign len_wr   = req_acc && cfg_sel && iomem_wstrb[0];
    assign busy     = state_q != StIdle;
    assign unused_bits = ^{iomem_addr[23:6], iomem_addr[1:0], iomem_wdata[31], iomem_wdata[28:6]};

    ctrl_tx_buf u_buf (
        .clk        (clk),
        .wr_en      (req_acc && buf_sel && !busy),
        .wr_idx     (iomem_addr[5:2]),
        .wr_strb    (iomem_wstrb),
        .wr_data    (iomem_wdata),
        .rd_idx     (iomem_addr[5:2]),
        .rd_data    (rd_word),
        .fetch_idx  (6'd16 + cnt_d),
        .fetch_byte (fetch_byte),
        .hdr_words  (hdr_words)
    );

    always_comb begin
        hdr_flat = '0;
        for (int k = 0; k < 16; k++) begin
            hdr_flat[HEADER_DWIDTH-1-8*k -: 8] = hdr_words[8*k +: 8];
        end
        hdr_flat[HdrCtrlBit] = 1'b0;
    end

    always_comb begin
        cfg_word = '0;
        cfg_word[CfgBusyBit] = busy;
        cfg_word[CfgErrBit]  = err_q;
        cfg_word[15:8]       = sent_q;
        cfg_word[5:0]        = len_q;
        rdata_d = '0;
        if (req_acc) begin
            rdata_d = buf_sel ? rd_word : cfg_word;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flen_d      = flen_q;
        len_d       = len_wr ? iomem_wdata[5:0] : len_q;
        sent_d      = sent_q;
        err_set     = 1'b0;
        b_fifo_wren = 1'b0;
        h_fifo_wren = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (send_req) begin
                    if (len_d == 6'd0) begin
                        err_set = 1'b1;
                    end else begin
                        state_d = StBody;
                        cnt_d   = '0;
                        flen_d  = clamp_len(len_d, MaxLen);
                    end
                end
            end
            StBody: begin
                if (!b_fifo_full) begin
                    b_fifo_wren = 1'b1;
                    cnt_d       = cnt_q + 6'd1;
                    if (cnt_q == flen_q - 6'd1) begin
                        state_d = StHeader;
                    end
                end
            end
            StHeader: begin
                if (!h_fifo_full) begin
                    h_fifo_wren = 1'b1;
                    sent_d      = sent_q + 8'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            flen_q  <= '0;
            len_q   <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            b_din_q <= '0;
            hdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flen_q  <= flen_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
            ready_q <= req_acc;
            rdata_q <= rdata_d;
            // Stage the byte that the next BODY cycle will push
            if (state_d == StBody) begin
                b_din_q <= {cnt_d == flen_d - 6'd1, fetch_byte};
            end
            if (state_q == StBody && state_d == StHeader) begin
                hdr_q <= hdr_flat;
            end
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign b_fifo_din  = b_din_q;
    assign h_fifo_din  = hdr_q;

endmodule

// File: tb/tb_ctrl_frame_injector.sv
// Directed sequence with random buffer contents, checked against a byte-array frame model.
module tb_ctrl_frame_injector;

    localparam logic [31:0] CfgAddr = 32'h1500_0000;
    localparam logic [31:0] BufAddr = 32'h0500_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] h_fifo_din;
    logic         h_fifo_wren;
    logic         h_fifo_full = 1'b0;
    logic [8:0]   b_fifo_din;
    logic         b_fifo_wren;
    logic         b_fifo_full = 1'b0;
    logic         iomem_valid = 1'b0;
    logic         iomem_ready;
    logic [3:0]   iomem_wstrb = '0;
    logic [31:0]  iomem_addr = '0;
    logic [31:0]  iomem_wdata = '0;
    logic [31:0]  iomem_rdata;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int push_while_full = 0;
    int exp_sent = 0;

    logic [7:0]   mbuf [64];
    logic [8:0]   bq[$];
    int           bt[$];
    logic [127:0] hq[$];
    int           ht[$];

    ctrl_frame_injector dut (
        .clk         (clk),
        .rst         (rst),
        .h_fifo_din  (h_fifo_din),
        .h_fifo_wren (h_fifo_wren),
        .h_fifo_full (h_fifo_full),
        .b_fifo_din  (b_fifo_din),
        .b_fifo_wren (b_fifo_wren),
        .b_fifo_full (b_fifo_full),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b_fifo_wren) begin
            bq.push_back(b_fifo_din);
            bt.push_back(cyc);
            if (b_fifo_full) push_while_full++;
        end
        if (h_fifo_wren) begin
            hq.push_back(h_fifo_din);
            ht.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int t, output logic [31:0] rd);
        int guard;
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        t = cyc;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (!iomem_ready && guard < 8);
        chk("bus_ready", 128'(iomem_ready), 128'(1));
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
    endtask

    task automatic buf_write(input int w, input logic [31:0] d, input logic [3:0] s,
                             input bit apply);
        int t;
        logic [31:0] rd;
        bus(BufAddr + 32'(4 * w), d, s, t, rd);
        if (apply) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mbuf[4*w+b] = d[8*b +: 8];
            end
        end
    endtask

    task automatic fill_random();
        for (int w = 0; w < 16; w++) buf_write(w, $urandom, 4'hF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            buf_write($urandom_range(0, 15), $urandom, 4'($urandom_range(1, 14)), 1'b1);
        end
    endtask

    task automatic cfg_read(output logic [31:0] v);
        int t;
        bus(CfgAddr, 32'h0, 4'h0, t, v);
    endtask

    task automatic send(input logic [5:0] len, output int t);
        logic [31:0] rd;
        bus(CfgAddr, 32'h4000_0000 | {26'b0, len}, 4'b1001, t, rd);
    endtask

    function automatic logic [127:0] exp_hdr();
        logic [127:0] h;
        for (int k = 0; k < 16; k++) h[127-8*k -: 8] = mbuf[k];
        h[114] = 1'b0;
        return h;
    endfunction

    task automatic clear_q();
        bq.delete(); bt.delete(); hq.delete(); ht.delete();
    endtask

    task automatic check_frame(input string tag, input int t, input int n, input int stall);
        int g = 0;
        while (hq.size() == 0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        chk({tag, ":hdr_count"}, 128'(hq.size()), 128'(1));
        chk({tag, ":body_count"}, 128'(bq.size()), 128'(n));
        if (hq.size() == 1 && bq.size() == n) begin
            for (int k = 0; k < n; k++) begin
                chk({tag, ":byte"}, 128'(bq[k]), 128'({k == n - 1, mbuf[16+k]}));
            end
            chk({tag, ":first_t"}, 128'(bt[0]), 128'(t + 1));
            chk({tag, ":last_t"}, 128'(bt[n-1]), 128'(t + n + stall));
            chk({tag, ":hdr_t"}, 128'(ht[0]), 128'(t + n + 1 + stall));
            chk({tag, ":hdr"}, hq[0], exp_hdr());
        end
        exp_sent++;
        clear_q();
    endtask

    initial begin
        int t, t2;
        logic [31:0] v;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(iomem_ready), 128'(0));
        chk("rst_rdata", 128'(iomem_rdata), 128'(0));
        chk("rst_bwren", 128'(b_fifo_wren), 128'(0));
        chk("rst_hwren", 128'(h_fifo_wren), 128'(0));
        chk("rst_bdin", 128'(b_fifo_din), 128'(0));
        chk("rst_hdin", h_fifo_din, 128'(0));
        rst = 1'b0;
        cfg_read(v);
        chk("rst_cfg", 128'(v), 128'(0));

        // Basic frame, length 8
        fill_random();
        bus(BufAddr + 32'd16, 32'h0, 4'h0, t, v);
        chk("readback_w4", 128'(v), 128'({mbuf[19], mbuf[18], mbuf[17], mbuf[16]}));
        send(6'd8, t);
        check_frame("len8", t, 8, 0);
        cfg_read(v);
        chk("len8_cnt", 128'(v[15:8]), 128'(exp_sent));
        chk("len8_busy", 128'(v[31]), 128'(0));
        chk("len8_len", 128'(v[5:0]), 128'(8));

        // Three cycles of body backpressure
        fill_random();
        send(6'd8, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_fifo_full = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        b_fifo_full = 1'b0;
        check_frame("stall", t, 8, 3);
        chk("no_push_full", 128'(push_while_full), 128'(0));

        // Zero length sets err, no traffic
        send(6'd0, t);
        repeat (20) @(posedge clk);
        #1;
        chk("len0_body", 128'(bq.size()), 128'(0));
        chk("len0_hdr", 128'(hq.size()), 128'(0));
        cfg_read(v);
        chk("len0_err", 128'(v[29]), 128'(1));
        bus(CfgAddr, 32'h2000_0000, 4'b1000, t, v);
        cfg_read(v);
        chk("err_clr", 128'(v[29]), 128'(0));

        // Oversize length clamps to 48
        fill_random();
        send(6'd60, t);
        check_frame("len60", t, 48, 0);

        // Send and buffer write while busy are ignored
        fill_random();
        send(6'd20, t);
        buf_write(5, ~{mbuf[23], mbuf[22], mbuf[21], mbuf[20]}, 4'hF, 1'b0);
        send(6'd20, t2);
        cfg_read(v);
        chk("busy_flag", 128'(v[31]), 128'(1));
        check_frame("busy", t, 20, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("busy_no_2nd_body", 128'(bq.size()), 128'(0));
        chk("busy_no_2nd_hdr", 128'(hq.size()), 128'(0));
        bus(BufAddr + 32'd20, 32'h0, 4'h0, t2, v);
        chk("busy_buf_kept", 128'(v), 128'({mbuf[23], mbuf[22], mbuf[21], mbuf[20]}));
        cfg_read(v);
        chk("busy_cnt", 128'(v[15:8]), 128'(exp_sent));

        // Reset in the middle of a body
        send(6'd30, t);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_bwren", 128'(b_fifo_wren), 128'(0));
        chk("midrst_hwren", 128'(h_fifo_wren), 128'(0));
        exp_sent = 0;
        cfg_read(v);
        chk("midrst_cfg", 128'(v), 128'(0));
        clear_q();
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_quiet", 128'(bq.size() + hq.size()), 128'(0));
        fill_random();
        send(6'd5, t);
        check_frame("after_rst", t, 5, 0);
        cfg_read(v);
        chk("after_rst_cnt", 128'(v[15:8]), 128'(exp_sent));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
